int_ctrl: RTL and testbench
===========================

# int_ctrl

Interrupt controller sitting between the interrupt sources (Counter_x channel outputs, debounced button pulses) and the Mips `INT` input; it is the responder side of the counter-to-CPU interrupt path. Edge or level sources are latched into a pending register, gated by a mask, prioritised, and presented to the CPU as one registered `INT` line. The CPU reads and clears state through four memory-mapped words decoded by MIO_BUS, and acknowledges service with a one-cycle `int_ack` strobe.

## Interface
- `N_SRC`, 4: number of interrupt sources, 1..8. Index 0 has the highest priority.
- `clk`  in  1  system clock; every register updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `irq_src`  in  N_SRC  raw source lines, synchronous to `clk`. Bit 0 is counter0_OUT.
- `sel`  in  1  chip select from MIO_BUS; the access targets this block.
- `mem_w`  in  1  write strobe, qualified by `sel`.
- `addr`  in  2  word offset, taken from address bits [3:2].
- `wdata`  in  32  write data from the CPU.
- `rdata`  out  32  read data; a combinational mux of register state.
- `int_ack`  in  1  one-cycle acknowledge pulse from the CPU (on eret).
- `INT`  out  1  registered interrupt request to the CPU.

## Operation
Register map (`addr`), with unused bits read as 0:
- 0 PENDING: read, write-1-to-clear.
- 1 MASK: read/write; bit=1 enables the source.
- 2 MODE: read/write; bit=1 selects level mode, bit=0 selects edge mode.
- 3 VECTOR: read-only.
  - [31] = valid.
  - [2:0] = index of the lowest-numbered set bit of PENDING & MASK.
  - When nothing is eligible, VECTOR reads 0.

Internal registers:
- `src_q`, `pending`, `mask`, `mode`, `INT`.
- All are cleared to 0 by `rst`, so after reset every source is in edge mode and masked.

Edge-mode pending bit i:
- `rise[i] = irq_src[i] & ~src_q[i]`.
- Set when `rise[i]`.
- Cleared by a PENDING write with `wdata[i]=1`, or by `int_ack` when VECTOR[2:0]==i and VECTOR valid.
- Set and clear in the same cycle: **set wins**, so a new event is never lost.

Level-mode pending bit i:
- The bit follows `irq_src[i]` each cycle.
- W1C and `int_ack` have no effect on it; the source must be deasserted at the peripheral.

Mode change:
- Switching a bit from level to edge keeps the current pending value.
- The first edge is then detected against `src_q`.

INT and masking:
- `INT` is registered from `|(pending & mask)` every cycle.
- Masking a source does not clear its pending bit; unmasking later raises `INT`.

Bus access:
- A write occurs only when `sel & mem_w`.
- Writes to VECTOR are ignored.
- A read returns the pre-update value when the same cycle also writes.

Acknowledge:
- `int_ack` while VECTOR is not valid is ignored.
- `int_ack` clears exactly one bit: the highest-priority eligible one.

Reset:
- Reset mid-operation drops all pending events.
- Edges present in the reset cycle are not recorded.
- `src_q` loads 0 in reset. A source held high across reset therefore produces one edge in the first cycle after reset.

## Timing
- `irq_src[i]` first high at edge k → `pending[i]=1` after edge k → `INT=1` after edge k+1, giving **2-cycle latency**.
- A W1C write or `int_ack` at edge k clears pending after edge k; `INT` falls after edge k+1 if nothing else is eligible.
- A MASK write at edge k changes `INT` after edge k+1.
- `rdata` is valid in the same cycle as `addr` and `sel`, with zero wait states.
- A source pulse of exactly one cycle is captured in edge mode.
- A held-high source produces only one edge.

## Test plan
- **Edge capture:** reset; MASK=0x1; pulse `irq_src[0]` for one cycle at edge 10.
  - PENDING=0x1 after edge 10.
  - `INT`=1 after edge 11.
  - VECTOR=0x80000000.
  - `int_ack` at edge 15 → PENDING=0 and `INT`=0 after edge 16.
- **Priority:** MASK=0xF; raise sources 1 and 3 together.
  - VECTOR=0x80000001.
  - After `int_ack`: PENDING=0x8 and VECTOR=0x80000003.
  - After a second `int_ack`: `INT`=0.
- **Set-wins:** source 2 edge in the same cycle as a W1C write of 0x4 → PENDING[2] stays 1.
- **Mask/unmask:** MASK=0; edge on source 0.
  - PENDING=0x1 with `INT`=0.
  - Write MASK=0x1 → `INT`=1 one cycle later.
  - VECTOR reads 0 while the source is masked.
- **Level mode:** MODE=0x2, MASK=0x2; hold `irq_src[1]` high.
  - W1C 0x2 and `int_ack` leave PENDING=0x2.
  - Drop the source → PENDING=0 next cycle and `INT`=0 the cycle after.
- **Reset mid-operation:** PENDING=0xF and MASK=0xF; assert `rst` for 1 cycle.
  - All registers read 0 and `INT`=0.
  - A source held high through reset produces PENDING bit = 1 one cycle after release.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: latches edge/level interrupt sources into PENDING, masks them,
// picks the lowest-index eligible source and drives a registered INT line.
// Latency: source edge -> PENDING after 1 edge, INT after 2; reads are combinational.
module int_ctrl #(
  parameter int N_SRC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             sel,
  input  logic             mem_w,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic             int_ack,
  output logic             INT
);

  localparam int PAD = 32 - N_SRC;

  localparam logic [1:0] A_PENDING = 2'd0;
  localparam logic [1:0] A_MASK    = 2'd1;
  localparam logic [1:0] A_MODE    = 2'd2;
  localparam logic [1:0] A_VECTOR  = 2'd3;

  logic [N_SRC-1:0] r_src_q;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_mode;
  logic             r_int;

  logic             w_wr;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_ack_clr;
  logic [N_SRC-1:0] w_pending_nxt;
  logic [2:0]       w_vec_idx;
  logic             w_vec_vld;
  logic [31:0]      w_vector;

  assign w_wr   = sel & mem_w;
  assign w_elig = r_pending & r_mask;
  assign w_rise = irq_src & ~r_src_q;
  assign w_w1c  = (w_wr && (addr == A_PENDING)) ? wdata[N_SRC-1:0] : '0;

  // Priority encoder: lowest-numbered eligible source wins.
  always_comb begin
    w_vec_idx = '0;
    w_vec_vld = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_vec_vld = 1'b1;
        w_vec_idx = 3'(i);
      end
    end
  end

  assign w_vector = {w_vec_vld, 28'd0, w_vec_idx};

  // Acknowledge clears only the bit currently reported by VECTOR.
  always_comb begin
    w_ack_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      w_ack_clr[i] = int_ack && w_vec_vld && (w_vec_idx == 3'(i));
    end
  end

  // Next PENDING: level bits track the pin; edge bits set on rise, and a
  // rise beats any clear in the same cycle so no event is lost.
  always_comb begin
    w_pending_nxt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_mode[i]) begin
        w_pending_nxt[i] = irq_src[i];
      end else begin
        w_pending_nxt[i] = w_rise[i] | (r_pending[i] & ~(w_w1c[i] | w_ack_clr[i]));
      end
    end
  end

  // Source history, pending, and INT; reset drops everything including
  // edges arriving in the reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_q   <= '0;
      r_pending <= '0;
      r_int     <= 1'b0;
    end else begin
      r_src_q   <= irq_src;
      r_pending <= w_pending_nxt;
      r_int     <= |w_elig;
    end
  end

  // CPU-writable configuration registers; VECTOR writes fall through.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
      r_mode <= '0;
    end else if (w_wr) begin
      if (addr == A_MASK) r_mask <= wdata[N_SRC-1:0];
      if (addr == A_MODE) r_mode <= wdata[N_SRC-1:0];
    end
  end

  // Read mux reflects current register state (pre-update on a write cycle).
  always_comb begin
    rdata = '0;
    case (addr)
      A_PENDING: rdata = {{PAD{1'b0}}, r_pending};
      A_MASK:    rdata = {{PAD{1'b0}}, r_mask};
      A_MODE:    rdata = {{PAD{1'b0}}, r_mode};
      A_VECTOR:  rdata = w_vector;
      default:   rdata = '0;
    endcase
  end

  assign INT = r_int;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: reset, edge capture, priority, set-wins,
// masking, level mode, mode switch, bus corner cases and mid-run reset.
module tb_int_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  irq_src;
  logic        sel;
  logic        mem_w;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        int_ack;
  logic        int_o;

  int checks;
  int failures;

  int_ctrl #(.N_SRC(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_src (irq_src),
    .sel     (sel),
    .mem_w   (mem_w),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .int_ack (int_ack),
    .INT     (int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; mem_w = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; mem_w = 1'b0; wdata = '0;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    sel = 1'b1; mem_w = 1'b0; addr = a;
    #1;
    chk(name, rdata, exp);
    sel = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; irq_src = '0; sel = 1'b0; mem_w = 1'b0;
    addr = '0; wdata = '0; int_ack = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_int", {31'd0, int_o}, 32'd0);
    rd("rst_pending", 2'd0, 32'h0);
    rd("rst_mask",    2'd1, 32'h0);
    rd("rst_mode",    2'd2, 32'h0);
    rd("rst_vector",  2'd3, 32'h0);

    // Edge capture of a one-cycle pulse
    wr(2'd1, 32'h1);
    irq_src = 4'b0001; tick(); irq_src = '0;
    rd("edge_pending", 2'd0, 32'h1);
    chk("edge_int_lat1", {31'd0, int_o}, 32'd0);
    tick();
    chk("edge_int_lat2", {31'd0, int_o}, 32'd1);
    rd("edge_vector", 2'd3, 32'h8000_0000);
    ack();
    rd("edge_ack_pending", 2'd0, 32'h0);
    chk("edge_ack_int_hold", {31'd0, int_o}, 32'd1);
    tick();
    chk("edge_ack_int_fall", {31'd0, int_o}, 32'd0);

    // Priority among sources 1 and 3
    wr(2'd1, 32'hF);
    irq_src = 4'b1010; tick(); irq_src = '0;
    rd("prio_vector1", 2'd3, 32'h8000_0001);
    tick();
    chk("prio_int", {31'd0, int_o}, 32'd1);
    ack();
    rd("prio_pending_after_ack", 2'd0, 32'h8);
    rd("prio_vector2", 2'd3, 32'h8000_0003);
    ack();
    rd("prio_pending_empty", 2'd0, 32'h0);
    tick();
    chk("prio_int_fall", {31'd0, int_o}, 32'd0);

    // Set wins over W1C in the same cycle; held-high source gives one edge
    irq_src = 4'b0100; tick(); irq_src = '0; tick();
    irq_src = 4'b0100; wr(2'd0, 32'h4);
    rd("setwins_pending", 2'd0, 32'h4);
    wr(2'd0, 32'h4);
    rd("held_high_no_reedge", 2'd0, 32'h0);
    irq_src = '0;
    tick(); tick();

    // Mask hides INT but keeps pending
    wr(2'd1, 32'h0);
    irq_src = 4'b0001; tick(); irq_src = '0;
    rd("mask_pending", 2'd0, 32'h1);
    tick();
    chk("mask_int_low", {31'd0, int_o}, 32'd0);
    rd("mask_vector_zero", 2'd3, 32'h0);
    wr(2'd1, 32'h1);
    chk("unmask_int_lat1", {31'd0, int_o}, 32'd0);
    tick();
    chk("unmask_int_lat2", {31'd0, int_o}, 32'd1);
    wr(2'd0, 32'h1);
    tick();

    // Level mode ignores W1C and ack
    wr(2'd2, 32'h2);
    wr(2'd1, 32'h2);
    rd("level_mode_rb", 2'd2, 32'h2);
    irq_src = 4'b0010; tick();
    rd("level_pending", 2'd0, 32'h2);
    wr(2'd0, 32'h2);
    rd("level_w1c_ignored", 2'd0, 32'h2);
    ack();
    rd("level_ack_ignored", 2'd0, 32'h2);
    chk("level_int", {31'd0, int_o}, 32'd1);
    irq_src = '0; tick();
    rd("level_drop_pending", 2'd0, 32'h0);
    chk("level_drop_int_hold", {31'd0, int_o}, 32'd1);
    tick();
    chk("level_drop_int_fall", {31'd0, int_o}, 32'd0);

    // Level -> edge switch keeps pending; no fresh edge from held source
    irq_src = 4'b0010; tick();
    wr(2'd2, 32'h0);
    tick();
    rd("switch_keep_pending", 2'd0, 32'h2);
    irq_src = '0; tick();
    rd("switch_edge_sticky", 2'd0, 32'h2);
    wr(2'd0, 32'h2);
    rd("switch_w1c", 2'd0, 32'h0);

    // Bus corners: VECTOR write ignored, read shows pre-write value
    wr(2'd3, 32'hFFFF_FFFF);
    rd("vector_write_ignored", 2'd3, 32'h0);
    sel = 1'b1; mem_w = 1'b1; addr = 2'd1; wdata = 32'hF;
    #1;
    chk("read_during_write", rdata, 32'h2);
    tick();
    sel = 1'b0; mem_w = 1'b0;
    rd("mask_after_write", 2'd1, 32'hF);

    // Reset mid-operation
    irq_src = 4'b1111; tick(); irq_src = '0; tick();
    rd("pre_reset_pending", 2'd0, 32'hF);
    chk("pre_reset_int", {31'd0, int_o}, 32'd1);
    irq_src = 4'b0001;
    rst = 1'b1; tick(); rst = 1'b0;
    rd("post_reset_pending", 2'd0, 32'h0);
    rd("post_reset_mask", 2'd1, 32'h0);
    chk("post_reset_int", {31'd0, int_o}, 32'd0);
    tick();
    rd("post_reset_held_edge", 2'd0, 32'h1);
    irq_src = '0;
    tick();
    chk("post_reset_masked_int", {31'd0, int_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
